tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux_pkg.sv | 16 +
 rtl/demux_slot_ctr.sv | 21 ++
 rtl/tdm_demux4.sv | 79 +++++++
 tb/tb_tdm_demux4.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared types and sizing for the 4-lane TDM demultiplexer.
package tdm_demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic logic is_last_slot(input logic [SLOT_W-1:0] s);
        return s == SLOT_W'(NUM_LANES - 1);
    endfunction

endpackage

// File: rtl/demux_slot_ctr.sv
// Lane pointer: wraps modulo NUM_LANES; load1 restarts a frame after a sync sample.
module demux_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            slot <= '0;
        else if (load1)
            slot <= SLOT_W'(1);
        else if (inc)
            slot <= slot + SLOT_W'(1);
    end

endmodule

// File: rtl/tdm_demux4.sv
// Serial TDM stream to 4-lane frame register with sync-based frame alignment.
module tdm_demux4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    input  logic                       sync,
    output logic [NUM_LANES*WIDTH-1:0] y,
    output logic                       frame_valid,
    output logic [SLOT_W-1:0]          slot,
    output logic                       locked,
    output logic                       sync_err
);

    state_e                               state;
    logic [NUM_LANES-2:0][WIDTH-1:0]      stg;
    logic                                 start;
    logic                                 resync;
    logic                                 lost;
    logic                                 adv;
    logic                                 frame_done;

    // start: sample goes to lane 0 (fresh lock or mid-frame resync).
    // adv: ordinary in-order sample in LOCKED.
    assign resync     = (state == LOCKED) && din_valid && sync && (slot != '0);
    assign lost       = (state == LOCKED) && din_valid && !sync && (slot == '0);
    assign start      = ((state == HUNT) && din_valid && sync) || resync;
    assign adv        = (state == LOCKED) && din_valid && !resync && !lost;
    assign frame_done = adv && is_last_slot(slot);
    assign locked     = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= HUNT;
        else if (start)
            state <= LOCKED;
        else if (lost)
            state <= HUNT;
    end

    demux_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .load1 (start),
        .inc   (adv),
        .slot  (slot)
    );

    // Lanes 0..NUM_LANES-2 are staged; the last lane goes straight from din to y.
    for (genvar k = 0; k < NUM_LANES - 1; k++) begin : g_stg
        logic wr;
        assign wr = (adv && (slot == SLOT_W'(k))) || (start && (k == 0));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                stg[k] <= '0;
            else if (wr)
                stg[k] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            if (frame_done)
                y <= {din, stg};
            frame_valid <= frame_done;
            sync_err    <= resync || lost;
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=4) with a frame scoreboard.
module tb_tdm_demux4;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          sync = 1'b0;
    logic [4*W-1:0] y;
    logic          frame_valid;
    logic [1:0]    slot;
    logic          locked;
    logic          sync_err;

    int n_chk = 0;
    int n_err = 0;
    int fv_cnt = 0;
    int serr_cnt = 0;
    int exp_fv = 0;
    int exp_serr = 0;
    logic [4*W-1:0] sb[$];

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .y           (y),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every frame pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid) begin
                fv_cnt++;
                n_chk++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_unexpected_frame: observed y=0x%0h expected no frame", y);
                end
                if (sb.size() != 0) begin
                    logic [4*W-1:0] e;
                    e = sb.pop_front();
                    n_chk++;
                    assert (y === e) else begin
                        n_err++;
                        $error("FAIL sb_frame: observed 0x%0h expected 0x%0h", y, e);
                    end
                end
            end
            if (sync_err)
                serr_cnt++;
            if (frame_valid || sync_err) begin
                n_chk++;
                assert (!(frame_valid && sync_err)) else begin
                    n_err++;
                    $error("FAIL excl: observed fv=%0b serr=%0b expected not both", frame_valid, sync_err);
                end
            end
        end
    end

    // Drive one accepted sample; returns 1ns after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic s);
        din = d;
        sync = s;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_serr", 32'(sync_err), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_slot", 32'(slot), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // Basic frame and latency
        sb.push_back(16'hDCBA); exp_fv++;
        send(4'hA, 1'b1);
        chk("s1_lock", 32'(locked), 32'h1);
        chk("s1_slot1", 32'(slot), 32'h1);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        send(4'hD, 1'b0);
        @(negedge clk);
        chk("s1_fv", 32'(frame_valid), 32'h1);
        chk("s1_y", 32'(y), 32'hDCBA);
        chk("s1_locked", 32'(locked), 32'h1);
        chk("s1_slot0", 32'(slot), 32'h0);
        @(negedge clk);
        chk("s1_fv_1cyc", 32'(frame_valid), 32'h0);
        idle(1);

        // No sync from reset: everything discarded
        do_reset();
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        idle(2);
        chk("s2_y", 32'(y), 32'h0);
        chk("s2_locked", 32'(locked), 32'h0);
        chk("s2_slot", 32'(slot), 32'h0);
        chk("s2_nofv", 32'(fv_cnt), 32'(exp_fv));

        // Mid-frame resync
        do_reset();
        sb.push_back(16'h4321); exp_fv++;
        send(4'h1, 1'b1);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        send(4'h5, 1'b1);
        send(4'h6, 1'b0);
        chk("s3_hold", 32'(y), 32'h4321);
        sb.push_back(16'hA987); exp_fv++; exp_serr++;
        send(4'h7, 1'b1);
        @(negedge clk);
        chk("s3_serr", 32'(sync_err), 32'h1);
        chk("s3_locked", 32'(locked), 32'h1);
        chk("s3_slot1", 32'(slot), 32'h1);
        chk("s3_hold2", 32'(y), 32'h4321);
        idle(1);
        send(4'h8, 1'b0);
        send(4'h9, 1'b0);
        send(4'hA, 1'b0);
        @(negedge clk);
        chk("s3_y", 32'(y), 32'hA987);
        idle(1);

        // Lost sync at slot 0
        exp_serr++;
        send(4'hE, 1'b0);
        @(negedge clk);
        chk("s4_serr", 32'(sync_err), 32'h1);
        chk("s4_unlock", 32'(locked), 32'h0);
        chk("s4_slot", 32'(slot), 32'h0);
        chk("s4_y", 32'(y), 32'hA987);
        idle(1);
        send(4'hF, 1'b0);
        chk("s4_hunt_slot", 32'(slot), 32'h0);

        // Gapped samples; sync without din_valid is ignored
        do_reset();
        sb.push_back(16'hDCBA); exp_fv++;
        send(4'hA, 1'b1);
        idle(3);
        send(4'hB, 1'b0);
        sync = 1'b1;
        idle(3);
        sync = 1'b0;
        chk("s5_gap_slot", 32'(slot), 32'h2);
        chk("s5_gap_lock", 32'(locked), 32'h1);
        send(4'hC, 1'b0);
        idle(3);
        send(4'hD, 1'b0);
        @(negedge clk);
        chk("s5_y", 32'(y), 32'hDCBA);
        idle(2);

        // Reset mid-frame discards the partial frame
        do_reset();
        send(4'h1, 1'b1);
        send(4'h2, 1'b0);
        do_reset();
        sb.push_back(16'h8765); exp_fv++;
        send(4'h5, 1'b1);
        send(4'h6, 1'b0);
        send(4'h7, 1'b0);
        send(4'h8, 1'b0);
        @(negedge clk);
        chk("s6_y", 32'(y), 32'h8765);
        idle(2);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("fv_count", 32'(fv_cnt), 32'(exp_fv));
        chk("serr_count", 32'(serr_cnt), 32'(exp_serr));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
